// File: rtl/tcp_conn_table_pkg.sv
// Shared types and constants for the active-open connection table.
//
// Contents:
//   - Session-table geometry: TCP_SESSION_ORDER (log2 depth) and TCP_CONN_DATA_BITS.
//   - rsid field widths: vfid / pid / dest, packed as {vfid, pid, dest}.
//   - Open/close request and response structs for the user side and the stack side.
//   - state_t enum for the tcp_conn_table controller.
//   - tcp_conn_entry(), which builds a tagged table word from an rsid.
//
// Optional feature macro: TCP_CONN_CLOSE_CHECK_EN adds the close-path states to state_t.
package tcp_conn_table_pkg;

  localparam int TCP_SESSION_ORDER   = 10;
  localparam int TCP_CONN_DATA_BITS  = 16;
  localparam int TCP_IP_ADDRESS_BITS = 32;
  localparam int TCP_IP_PORT_BITS    = 16;
  localparam int TCP_SID_BITS        = 16;
  localparam int N_REGIONS_BITS      = 4;
  localparam int N_PID_BITS          = 6;
  localparam int N_DEST_BITS         = 4;
  localparam int TCP_RSESSION_BITS   = N_REGIONS_BITS + N_PID_BITS + N_DEST_BITS;

  // A table word is {tag, rsid}; the tag occupies the two bits above the rsid.
  localparam logic [1:0] TCP_CONN_VALID_TAG = 2'b01;

  typedef struct packed {
    logic [TCP_IP_ADDRESS_BITS-1:0] ip_address;
    logic [TCP_IP_PORT_BITS-1:0]    ip_port;
    logic [N_REGIONS_BITS-1:0]      vfid;
    logic [N_PID_BITS-1:0]          pid;
    logic [N_DEST_BITS-1:0]         dest;
  } tcp_open_req_u_t;

  typedef struct packed {
    logic [TCP_IP_ADDRESS_BITS-1:0] ip_address;
    logic [TCP_IP_PORT_BITS-1:0]    ip_port;
  } tcp_open_req_t;

  typedef struct packed {
    logic [TCP_SID_BITS-1:0]        sid;
    logic [TCP_IP_ADDRESS_BITS-1:0] ip_address;
    logic [TCP_IP_PORT_BITS-1:0]    ip_port;
    logic                           success;
  } tcp_open_rsp_t;

  typedef struct packed {
    logic [TCP_SID_BITS-1:0]        sid;
    logic [TCP_IP_ADDRESS_BITS-1:0] ip_address;
    logic [TCP_IP_PORT_BITS-1:0]    ip_port;
    logic                           success;
    logic [N_REGIONS_BITS-1:0]      vfid;
  } tcp_open_rsp_u_t;

  typedef struct packed {
    logic [TCP_SID_BITS-1:0]   sid;
    logic [N_REGIONS_BITS-1:0] vfid;
  } tcp_close_req_u_t;

  typedef struct packed {
    logic [TCP_SID_BITS-1:0] sid;
  } tcp_close_req_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND,
    ST_RSP_WAIT
`ifdef TCP_CONN_CLOSE_CHECK_EN
    ,
    ST_CLOSE_LUP,
    ST_CLOSE_WAIT,
    ST_CLOSE_CHECK,
    ST_CLOSE_SEND
`endif
  } state_t;

  // The tag plus rsid exactly fill the table word (2 + 14 = 16).
  function automatic logic [TCP_CONN_DATA_BITS-1:0] tcp_conn_entry(
    input logic [TCP_RSESSION_BITS-1:0] rsid
  );
    return {TCP_CONN_VALID_TAG, rsid};
  endfunction

endpackage

// File: rtl/tcp_conn_table_ram_tp_c.sv
// True two-port RAM with per-byte write enables and registered read data.
//
// Ports (both ports identical, independent address/enable):
//   clk                      clock
//   a_we / b_we    [N/8]     byte write enables
//   a_addr / b_addr          word address
//   a_data_in / b_data_in    write data
//   a_data_out / b_data_out  registered read data (read-first: a read of the
//                            word being written returns the previous contents)
//
// Contents are not reset; the owner is expected to initialise them.
module ram_tp_c #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 16
) (
  input  logic                   clk,
  input  logic [DATA_BITS/8-1:0] a_we,
  input  logic [ADDR_BITS-1:0]   a_addr,
  input  logic [DATA_BITS-1:0]   a_data_in,
  output logic [DATA_BITS-1:0]   a_data_out,
  input  logic [DATA_BITS/8-1:0] b_we,
  input  logic [ADDR_BITS-1:0]   b_addr,
  input  logic [DATA_BITS-1:0]   b_data_in,
  output logic [DATA_BITS-1:0]   b_data_out
);

  localparam int N_BYTES = DATA_BITS / 8;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BYTES; i++) begin
      if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_data_in[i*8 +: 8];
      if (b_we[i]) mem[b_addr][i*8 +: 8] <= b_data_in[i*8 +: 8];
    end
    a_data_out <= mem[a_addr];
    b_data_out <= mem[b_addr];
  end

endmodule

// File: rtl/tcp_conn_table.sv
// Active-open connection table.
//
// Accepts user open requests, forwards them to the TCP stack and passes the
// stack's response back to the issuing vFPGA. Successful opens record
// sid -> rsid {vfid, pid, dest} in a session table whose second port serves
// RX/notify routing lookups.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_open_req_*             user open request  {ip, port, vfid, pid, dest}
//   m_open_req_*             open request to the stack {ip, port}
//   s_open_rsp_*             stack response {sid, ip, port, success}
//   m_open_rsp_*             response to the user {sid, ip, port, success, vfid}
//   s_close_req_*            user close {sid, vfid}        (close build only)
//   m_close_req_*            close to the stack {sid}      (close build only)
//   sid_addr                 lookup address (1-cycle registered read)
//   rsid_out                 table word at sid_addr
//
// Optional feature macro: TCP_CONN_CLOSE_CHECK_EN enables the close path with
// the ownership check and entry clear. Without it the close ports are absent
// and entries are only ever overwritten by later opens.
module tcp_conn_table
  import tcp_conn_table_pkg::*;
(
  input  logic                          aclk,
  input  logic                          aresetn,

  input  logic                          s_open_req_valid,
  output logic                          s_open_req_ready,
  input  tcp_open_req_u_t               s_open_req_data,

  output logic                          m_open_req_valid,
  input  logic                          m_open_req_ready,
  output tcp_open_req_t                 m_open_req_data,

  input  logic                          s_open_rsp_valid,
  output logic                          s_open_rsp_ready,
  input  tcp_open_rsp_t                 s_open_rsp_data,

  output logic                          m_open_rsp_valid,
  input  logic                          m_open_rsp_ready,
  output tcp_open_rsp_u_t               m_open_rsp_data,

`ifdef TCP_CONN_CLOSE_CHECK_EN
  input  logic                          s_close_req_valid,
  output logic                          s_close_req_ready,
  input  tcp_close_req_u_t              s_close_req_data,

  output logic                          m_close_req_valid,
  input  logic                          m_close_req_ready,
  output tcp_close_req_t                m_close_req_data,
`endif

  input  logic [TCP_SESSION_ORDER-1:0]  sid_addr,
  output logic [TCP_CONN_DATA_BITS-1:0] rsid_out
);

  localparam int N_WE = TCP_CONN_DATA_BITS / 8;

  state_t                          state_q,  state_d;
  logic [TCP_SESSION_ORDER-1:0]    cnt_q,    cnt_d;
  logic [TCP_IP_ADDRESS_BITS-1:0]  ip_q,     ip_d;
  logic [TCP_IP_PORT_BITS-1:0]     port_q,   port_d;
  logic [TCP_RSESSION_BITS-1:0]    rsid_q,   rsid_d;
  logic [N_REGIONS_BITS-1:0]       vfid_q,   vfid_d;

  logic [N_WE-1:0]                 ram_a_we;
  logic [TCP_SESSION_ORDER-1:0]    ram_a_addr;
  logic [TCP_CONN_DATA_BITS-1:0]   ram_a_din;
  logic [TCP_CONN_DATA_BITS-1:0]   ram_a_dout;

`ifdef TCP_CONN_CLOSE_CHECK_EN
  logic [TCP_SID_BITS-1:0]         close_sid_q,  close_sid_d;
  logic [N_REGIONS_BITS-1:0]       close_vfid_q, close_vfid_d;
  logic                            close_ok;

  // Owner check: entry must carry the valid tag and the requester's vfid.
  assign close_ok = (ram_a_dout[TCP_CONN_DATA_BITS-1 -: 2] == TCP_CONN_VALID_TAG) &&
                    (ram_a_dout[TCP_RSESSION_BITS-1 -: N_REGIONS_BITS] == close_vfid_q);
`else
  logic ram_a_unused;
  assign ram_a_unused = ^ram_a_dout;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ip_d    = ip_q;
    port_d  = port_q;
    rsid_d  = rsid_q;
    vfid_d  = vfid_q;

    s_open_req_ready = 1'b0;
    m_open_req_valid = 1'b0;
    s_open_rsp_ready = 1'b0;
    m_open_rsp_valid = 1'b0;

    m_open_req_data.ip_address = ip_q;
    m_open_req_data.ip_port    = port_q;

    // Response data is a straight pass-through plus the captured vfid.
    m_open_rsp_data.sid        = s_open_rsp_data.sid;
    m_open_rsp_data.ip_address = s_open_rsp_data.ip_address;
    m_open_rsp_data.ip_port    = s_open_rsp_data.ip_port;
    m_open_rsp_data.success    = s_open_rsp_data.success;
    m_open_rsp_data.vfid       = vfid_q;

    ram_a_we   = '0;
    ram_a_addr = '0;
    ram_a_din  = '0;

`ifdef TCP_CONN_CLOSE_CHECK_EN
    close_sid_d          = close_sid_q;
    close_vfid_d         = close_vfid_q;
    s_close_req_ready    = 1'b0;
    m_close_req_valid    = 1'b0;
    m_close_req_data.sid = close_sid_q;
`endif

    case (state_q)
      ST_INIT: begin
        ram_a_we   = '1;
        ram_a_addr = cnt_q;
        cnt_d      = cnt_q + TCP_SESSION_ORDER'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        // Drain any response left over from a transaction aborted by reset.
        s_open_rsp_ready = 1'b1;
`ifdef TCP_CONN_CLOSE_CHECK_EN
        if (s_close_req_valid) begin
          s_close_req_ready = 1'b1;
          close_sid_d       = s_close_req_data.sid;
          close_vfid_d      = s_close_req_data.vfid;
          state_d           = ST_CLOSE_LUP;
        end else
`endif
        if (s_open_req_valid) begin
          s_open_req_ready = 1'b1;
          ip_d             = s_open_req_data.ip_address;
          port_d           = s_open_req_data.ip_port;
          rsid_d           = {s_open_req_data.vfid, s_open_req_data.pid, s_open_req_data.dest};
          vfid_d           = s_open_req_data.vfid;
          state_d          = ST_SEND;
        end
      end

      ST_SEND: begin
        m_open_req_valid = 1'b1;
        if (m_open_req_ready) state_d = ST_RSP_WAIT;
      end

      ST_RSP_WAIT: begin
        s_open_rsp_ready = m_open_rsp_ready;
        m_open_rsp_valid = s_open_rsp_valid;
        ram_a_addr       = s_open_rsp_data.sid[TCP_SESSION_ORDER-1:0];
        ram_a_din        = tcp_conn_entry(rsid_q);
        if (s_open_rsp_valid && m_open_rsp_ready) begin
          if (s_open_rsp_data.success) ram_a_we = '1;
          state_d = ST_IDLE;
        end
      end

`ifdef TCP_CONN_CLOSE_CHECK_EN
      // Address is held through the lookup so the registered word is stable in CHECK.
      ST_CLOSE_LUP: begin
        ram_a_addr = close_sid_q[TCP_SESSION_ORDER-1:0];
        state_d    = ST_CLOSE_WAIT;
      end

      ST_CLOSE_WAIT: begin
        ram_a_addr = close_sid_q[TCP_SESSION_ORDER-1:0];
        state_d    = ST_CLOSE_CHECK;
      end

      ST_CLOSE_CHECK: begin
        ram_a_addr = close_sid_q[TCP_SESSION_ORDER-1:0];
        state_d    = close_ok ? ST_CLOSE_SEND : ST_IDLE;
      end

      ST_CLOSE_SEND: begin
        m_close_req_valid = 1'b1;
        ram_a_addr        = close_sid_q[TCP_SESSION_ORDER-1:0];
        if (m_close_req_ready) begin
          ram_a_we = '1;
          state_d  = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ip_q         <= '0;
      port_q       <= '0;
      rsid_q       <= '0;
      vfid_q       <= '0;
`ifdef TCP_CONN_CLOSE_CHECK_EN
      close_sid_q  <= '0;
      close_vfid_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ip_q         <= ip_d;
      port_q       <= port_d;
      rsid_q       <= rsid_d;
      vfid_q       <= vfid_d;
`ifdef TCP_CONN_CLOSE_CHECK_EN
      close_sid_q  <= close_sid_d;
      close_vfid_q <= close_vfid_d;
`endif
    end
  end

  // Port A belongs to the controller; port B is a read-only routing lookup.
  ram_tp_c #(
    .ADDR_BITS (TCP_SESSION_ORDER),
    .DATA_BITS (TCP_CONN_DATA_BITS)
  ) u_session_table (
    .clk        (aclk),
    .a_we       (ram_a_we),
    .a_addr     (ram_a_addr),
    .a_data_in  (ram_a_din),
    .a_data_out (ram_a_dout),
    .b_we       ('0),
    .b_addr     (sid_addr),
    .b_data_in  ('0),
    .b_data_out (rsid_out)
  );

endmodule

// File: tb/tb_tcp_conn_table.sv
// Directed bench for tcp_conn_table. Expected user responses are queued when
// the stack response is driven and popped when the DUT hands them out.
`timescale 1ns/1ps
module tb_tcp_conn_table;
  import tcp_conn_table_pkg::*;

  logic                          aclk    = 1'b0;
  logic                          aresetn = 1'b1;
  logic                          s_open_req_valid = 1'b0;
  logic                          s_open_req_ready;
  tcp_open_req_u_t               s_open_req_data  = '0;
  logic                          m_open_req_valid;
  logic                          m_open_req_ready = 1'b0;
  tcp_open_req_t                 m_open_req_data;
  logic                          s_open_rsp_valid = 1'b0;
  logic                          s_open_rsp_ready;
  tcp_open_rsp_t                 s_open_rsp_data  = '0;
  logic                          m_open_rsp_valid;
  logic                          m_open_rsp_ready = 1'b0;
  tcp_open_rsp_u_t               m_open_rsp_data;
`ifdef TCP_CONN_CLOSE_CHECK_EN
  logic                          s_close_req_valid = 1'b0;
  logic                          s_close_req_ready;
  tcp_close_req_u_t              s_close_req_data  = '0;
  logic                          m_close_req_valid;
  logic                          m_close_req_ready = 1'b0;
  tcp_close_req_t                m_close_req_data;
`endif
  logic [TCP_SESSION_ORDER-1:0]  sid_addr = '0;
  logic [TCP_CONN_DATA_BITS-1:0] rsid_out;

  int total = 0;
  int bad   = 0;
  tcp_open_rsp_u_t exp_q[$];

  tcp_conn_table dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_open_req_valid  (s_open_req_valid),
    .s_open_req_ready  (s_open_req_ready),
    .s_open_req_data   (s_open_req_data),
    .m_open_req_valid  (m_open_req_valid),
    .m_open_req_ready  (m_open_req_ready),
    .m_open_req_data   (m_open_req_data),
    .s_open_rsp_valid  (s_open_rsp_valid),
    .s_open_rsp_ready  (s_open_rsp_ready),
    .s_open_rsp_data   (s_open_rsp_data),
    .m_open_rsp_valid  (m_open_rsp_valid),
    .m_open_rsp_ready  (m_open_rsp_ready),
    .m_open_rsp_data   (m_open_rsp_data),
`ifdef TCP_CONN_CLOSE_CHECK_EN
    .s_close_req_valid (s_close_req_valid),
    .s_close_req_ready (s_close_req_ready),
    .s_close_req_data  (s_close_req_data),
    .m_close_req_valid (m_close_req_valid),
    .m_close_req_ready (m_close_req_ready),
    .m_close_req_data  (m_close_req_data),
`endif
    .sid_addr          (sid_addr),
    .rsid_out          (rsid_out)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic tcp_open_req_u_t mk_req(input logic [31:0] ip, input logic [15:0] port,
                                             input logic [3:0] vfid, input logic [5:0] pid,
                                             input logic [3:0] dest);
    tcp_open_req_u_t r;
    r.ip_address = ip;
    r.ip_port    = port;
    r.vfid       = vfid;
    r.pid        = pid;
    r.dest       = dest;
    return r;
  endfunction

  function automatic logic [15:0] mk_word(input logic [3:0] vfid, input logic [5:0] pid,
                                          input logic [3:0] dest);
    return {2'b01, vfid, pid, dest};
  endfunction

  // Hold the request valid and count cycles until the DUT accepts it.
  task automatic open_accept(input tcp_open_req_u_t req, input int bound, output int n);
    s_open_req_data  = req;
    s_open_req_valid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_open_req_ready && n < bound) begin
      @(negedge aclk);
      n++;
    end
    check("open_req_accepted", s_open_req_ready, 1'b1);
    @(posedge aclk); #1;
    s_open_req_valid = 1'b0;
  endtask

  task automatic open_send(input tcp_open_req_u_t req, input int stall);
    tcp_open_req_t want;
    want.ip_address  = req.ip_address;
    want.ip_port     = req.ip_port;
    m_open_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      check("m_open_req_valid_held", m_open_req_valid, 1'b1);
      check("m_open_req_data_stable", m_open_req_data, want);
      @(posedge aclk); #1;
    end
    m_open_req_ready = 1'b1;
    @(negedge aclk);
    check("m_open_req_valid", m_open_req_valid, 1'b1);
    check("m_open_req_data", m_open_req_data, want);
    @(posedge aclk); #1;
    m_open_req_ready = 1'b0;
  endtask

  task automatic open_rsp(input tcp_open_req_u_t req, input logic [15:0] sid,
                          input logic success, input int stall);
    tcp_open_rsp_u_t want;
    s_open_rsp_data.sid        = sid;
    s_open_rsp_data.ip_address = req.ip_address;
    s_open_rsp_data.ip_port    = req.ip_port;
    s_open_rsp_data.success    = success;
    s_open_rsp_valid           = 1'b1;
    want.sid        = sid;
    want.ip_address = req.ip_address;
    want.ip_port    = req.ip_port;
    want.success    = success;
    want.vfid       = req.vfid;
    exp_q.push_back(want);
    m_open_rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      check("m_open_rsp_valid_held", m_open_rsp_valid, 1'b1);
      check("s_open_rsp_ready_bp", s_open_rsp_ready, 1'b0);
      check("m_open_rsp_data_stable", m_open_rsp_data, exp_q[0]);
      @(posedge aclk); #1;
    end
    m_open_rsp_ready = 1'b1;
    @(negedge aclk);
    check("m_open_rsp_valid", m_open_rsp_valid, 1'b1);
    check("s_open_rsp_ready", s_open_rsp_ready, 1'b1);
    if (m_open_rsp_valid && exp_q.size() > 0) check("m_open_rsp_data", m_open_rsp_data, exp_q.pop_front());
    @(posedge aclk); #1;
    s_open_rsp_valid = 1'b0;
    m_open_rsp_ready = 1'b0;
  endtask

  task automatic read_entry(input logic [TCP_SESSION_ORDER-1:0] addr, output logic [15:0] w);
    sid_addr = addr;
    @(posedge aclk); #1;
    w = rsid_out;
  endtask

`ifdef TCP_CONN_CLOSE_CHECK_EN
  task automatic close_req(input logic [15:0] sid, input logic [3:0] vfid, input int want_sends);
    int sends;
    s_close_req_data.sid  = sid;
    s_close_req_data.vfid = vfid;
    s_close_req_valid     = 1'b1;
    m_close_req_ready     = 1'b1;
    @(negedge aclk);
    check("s_close_req_ready", s_close_req_ready, 1'b1);
    @(posedge aclk); #1;
    s_close_req_valid = 1'b0;
    sends = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (m_close_req_valid && m_close_req_ready) begin
        sends++;
        check("m_close_req_sid", m_close_req_data.sid, sid);
      end
    end
    @(posedge aclk); #1;
    m_close_req_ready = 1'b0;
    check("m_close_req_count", sends, want_sends);
  endtask
`endif

  initial begin
    tcp_open_req_u_t r1, r2, r3, r4, r5;
    logic [15:0] w;
    int n;

    r1 = mk_req(32'h0A000001, 16'd5001, 4'd2, 6'd3, 4'd1);
    r2 = mk_req(32'h0A000002, 16'd6000, 4'd6, 6'd9, 4'd2);
    r3 = mk_req(32'hC0A80105, 16'd80,   4'd5, 6'd1, 4'd2);
    r4 = mk_req(32'h0A0000FF, 16'd443,  4'd3, 6'd7, 4'd0);
    r5 = mk_req(32'h0B000001, 16'd22,   4'd1, 6'd2, 4'd3);

    // Reset: produce a real falling edge, hold, check outputs.
    #2 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    check("rst_s_open_req_ready", s_open_req_ready, 1'b0);
    check("rst_m_open_req_valid", m_open_req_valid, 1'b0);
    check("rst_s_open_rsp_ready", s_open_rsp_ready, 1'b0);
    check("rst_m_open_rsp_valid", m_open_rsp_valid, 1'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Sweep: request held from release; acceptance only after 1024 cycles.
    open_accept(r1, 2000, n);
    check("sweep_cycles", n, 1024);
    open_send(r1, 0);
    sid_addr = 10'd7;
    open_rsp(r1, 16'd7, 1'b1, 0);
    // Lookup on the cycle of the write returns the old word.
    check("entry7_read_first", rsid_out, 16'h0000);
    @(posedge aclk); #1;
    check("entry7_after_open", rsid_out, mk_word(4'd2, 6'd3, 4'd1));

    read_entry(10'd0, w);    check("init_entry0",    w, 16'h0000);
    read_entry(10'd511, w);  check("init_entry511",  w, 16'h0000);
    read_entry(10'd1023, w); check("init_entry1023", w, 16'h0000);

    // Failed open: response forwarded, table untouched.
    open_accept(r2, 20, n);
    check("idle_accept_latency", n, 0);
    open_send(r2, 0);
    open_rsp(r2, 16'd9, 1'b0, 0);
    read_entry(10'd9, w);    check("entry9_after_fail", w, 16'h0000);

    // Backpressure on both the stack request and the user response; upper sid bits ignored.
    open_accept(r3, 20, n);
    check("bp_accept_latency", n, 0);
    open_send(r3, 5);
    open_rsp(r3, 16'hFC14, 1'b1, 3);
    read_entry(10'd20, w);   check("entry20_after_bp", w, mk_word(4'd5, 6'd1, 4'd2));
    open_accept(r5, 20, n);
    check("bp_back_to_idle", n, 0);
    open_send(r5, 0);
    open_rsp(r5, 16'd40, 1'b1, 0);
    read_entry(10'd40, w);   check("entry40", w, mk_word(4'd1, 6'd2, 4'd3));
    read_entry(10'd7, w);    check("entry7_kept", w, mk_word(4'd2, 6'd3, 4'd1));

`ifdef TCP_CONN_CLOSE_CHECK_EN
    // Non-owner close is dropped.
    close_req(16'd7, 4'd4, 0);
    read_entry(10'd7, w);    check("entry7_after_bad_close", w, mk_word(4'd2, 6'd3, 4'd1));
    // Owner close goes out once and clears the entry.
    close_req(16'd7, 4'd2, 1);
    read_entry(10'd7, w);    check("entry7_after_close", w, 16'h0000);
    // Close on an empty entry is dropped.
    close_req(16'd7, 4'd2, 0);

    // Close and open together: close first, then the open.
    s_open_req_data   = r4;
    s_open_req_valid  = 1'b1;
    s_close_req_data.sid  = 16'd20;
    s_close_req_data.vfid = 4'd5;
    s_close_req_valid = 1'b1;
    m_close_req_ready = 1'b1;
    @(negedge aclk);
    check("both_close_ready", s_close_req_ready, 1'b1);
    check("both_open_not_ready", s_open_req_ready, 1'b0);
    @(posedge aclk); #1;
    s_close_req_valid = 1'b0;
    n = 0;
    begin
      int sends;
      sends = 0;
      @(negedge aclk);
      while (!s_open_req_ready && n < 20) begin
        if (m_close_req_valid) sends++;
        @(negedge aclk);
        n++;
      end
      check("both_close_sent", sends, 1);
    end
    check("both_open_accepted", s_open_req_ready, 1'b1);
    @(posedge aclk); #1;
    s_open_req_valid  = 1'b0;
    m_close_req_ready = 1'b0;
    open_send(r4, 0);
    open_rsp(r4, 16'd21, 1'b1, 0);
    read_entry(10'd20, w);   check("entry20_after_close", w, 16'h0000);
    read_entry(10'd21, w);   check("entry21_after_open", w, mk_word(4'd3, 6'd7, 4'd0));
`endif

    // Reset while waiting on the stack response.
    open_accept(r4, 20, n);
    open_send(r4, 0);
    s_open_rsp_data.sid        = 16'd7;
    s_open_rsp_data.ip_address = r4.ip_address;
    s_open_rsp_data.ip_port    = r4.ip_port;
    s_open_rsp_data.success    = 1'b1;
    s_open_rsp_valid = 1'b1;
    m_open_rsp_ready = 1'b0;
    @(negedge aclk);
    check("rspwait_m_open_rsp_valid", m_open_rsp_valid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_m_open_rsp_valid", m_open_rsp_valid, 1'b0);
    check("midrst_s_open_rsp_ready", s_open_rsp_ready, 1'b0);
    check("midrst_m_open_req_valid", m_open_req_valid, 1'b0);
    check("midrst_s_open_req_ready", s_open_req_ready, 1'b0);
    s_open_rsp_valid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    open_accept(r5, 2000, n);
    check("resweep_cycles", n, 1024);
    open_send(r5, 0);
    open_rsp(r5, 16'd50, 1'b1, 0);
    read_entry(10'd7, w);    check("entry7_after_resweep",  w, 16'h0000);
    read_entry(10'd40, w);   check("entry40_after_resweep", w, 16'h0000);
    read_entry(10'd50, w);   check("entry50_after_resweep", w, mk_word(4'd1, 6'd2, 4'd3));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
